// File: rtl/mips_shift_unit.sv
// mips_shift_unit: iterative shift execution unit for the MIPS datapath.
// Each SHIFT cycle moves the working value by up to MAX_STEP bit positions
// until the truncated shift amount is used up. The result is offered on a
// valid/ready handshake and held stable under back-pressure.
//
// Optional feature: define MIPS_SHIFT_ROTATE_EN to build the rotate-right
// datapath for op=01. Without it, op=01 behaves as SLL.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   flush      synchronous abort back to IDLE
//   in_valid   request present
//   in_ready   request can be accepted (IDLE and not in reset)
//   op         00 SLL, 10 SRL, 11 SRA, 01 ROTR
//   operand    value to shift
//   shamt_src  shift amount source; only the low SHAMT_W bits are used
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     shifted value
//   busy       unit is in SHIFT or DONE
`timescale 1ns/1ps

module mips_shift_unit #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned SHAMT_W  = $clog2(WIDTH),
   parameter int unsigned MAX_STEP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand,
   input  logic [WIDTH-1:0] shamt_src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int unsigned STEP_W = $clog2(MAX_STEP) + 1;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_ROTR = 2'b01;
   localparam logic [1:0] OP_SRL  = 2'b10;
   localparam logic [1:0] OP_SRA  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [1:0]         op_in_c;
   logic [SHAMT_W-1:0] amt_c;
   logic [STEP_W-1:0]  step_c;
   logic [WIDTH-1:0]   shifted_c;
   logic               unused_shamt_c;

   // Upper shift-amount bits are ignored (modulo-WIDTH shift semantics).
   assign amt_c          = shamt_src[SHAMT_W-1:0];
   assign unused_shamt_c = ^shamt_src[WIDTH-1:SHAMT_W];

   // Without the rotate datapath, op=01 is folded onto SLL at request time.
`ifdef MIPS_SHIFT_ROTATE_EN
   assign op_in_c = op;
`else
   assign op_in_c = (op == OP_ROTR) ? OP_SLL : op;
`endif

   // Bits to move this cycle: min(remaining, MAX_STEP).
   always_comb begin
      if (32'(rem_q) > MAX_STEP) begin
         step_c = STEP_W'(MAX_STEP);
      end else begin
         step_c = STEP_W'(rem_q);
      end
   end

   // One partial shift of the working register.
   always_comb begin
      shifted_c = work_q << step_c;
      case (op_q)
         OP_SRL:  shifted_c = work_q >> step_c;
         // MSB never changes under >>>, so the original sign is replicated.
         OP_SRA:  shifted_c = WIDTH'($signed(work_q) >>> step_c);
`ifdef MIPS_SHIFT_ROTATE_EN
         OP_ROTR: shifted_c = (work_q >> step_c)
                            | (work_q << ((SHAMT_W+1)'(WIDTH) - (SHAMT_W+1)'(step_c)));
`endif
         default: shifted_c = work_q << step_c;
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      work_d      = work_q;
      rem_d       = rem_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;

      if (flush) begin
         state_d     = S_IDLE;
         rem_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op_d    = op_in_c;
                  work_d  = operand;
                  rem_d   = amt_c;
                  state_d = (amt_c == '0) ? S_DONE : S_SHIFT;
               end
            end
            S_SHIFT: begin
               work_d = shifted_c;
               rem_d  = rem_q - SHAMT_W'(step_c);
               if (rem_q == SHAMT_W'(step_c)) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               // First DONE cycle publishes the result; it is then held.
               if (!out_valid_q) begin
                  result_d    = work_q;
                  out_valid_d = 1'b1;
               end else if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
            default: begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_SLL;
         work_q      <= '0;
         rem_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         work_q      <= work_d;
         rem_q       <= rem_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // in_ready drops immediately while reset is asserted.
   assign in_ready  = reset && (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;

endmodule
